// File: rtl/jesd204b_scrambler_mlane.sv
// Multi-lane JESD204B self-synchronous scrambler (1 + x^14 + x^15), one register stage.
// Define JESD204B_SCR_DESCRAMBLE_EN to honour the mode input (descramble feedback); otherwise it always scrambles.
module jesd204b_scrambler_mlane #(
    parameter int          LANES      = 4,
    parameter int          LANE_WIDTH = 32,
    parameter logic [14:0] SEED       = 15'h7F80
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    input  logic                        mode,
    input  logic                        seed_load,
    input  logic [14:0]                 seed_value,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*LANE_WIDTH-1:0] in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*LANE_WIDTH-1:0] out_data,
    output logic [15:0]                 beat_count
);

    localparam int W = LANES * LANE_WIDTH;

    logic         r_out_valid;
    logic [W-1:0] r_out_data;
    logic [15:0]  r_beat_count;
    logic         w_accept;
    logic [W-1:0] w_scr_data;

`ifdef JESD204B_SCR_DESCRAMBLE_EN
    logic w_descr;
    assign w_descr = mode;
`else
    logic w_unused_mode;
    assign w_unused_mode = mode;
`endif

    assign in_ready   = !r_out_valid || out_ready;
    assign w_accept   = in_valid && in_ready;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign beat_count = r_beat_count;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [14:0]           r_state;
            logic [14:0]           w_start;
            logic [14:0]           w_lane_end;
            logic [LANE_WIDTH-1:0] w_lane_out;

            // A coincident seed_load restarts this beat from seed_value.
            assign w_start = seed_load ? seed_value : r_state;

            always_comb begin
                logic [14:0] v_s;
                logic        v_d;
                logic        v_y;
                v_s        = w_start;
                v_d        = 1'b0;
                v_y        = 1'b0;
                w_lane_out = '0;
                for (int j = LANE_WIDTH - 1; j >= 0; j--) begin
                    v_d           = in_data[gi*LANE_WIDTH + j];
                    v_y           = v_d ^ v_s[14] ^ v_s[13];
                    w_lane_out[j] = v_y;
`ifdef JESD204B_SCR_DESCRAMBLE_EN
                    v_s = {v_s[13:0], (w_descr ? v_d : v_y)};
`else
                    v_s = {v_s[13:0], v_y};
`endif
                end
                w_lane_end = v_s;
            end

            assign w_scr_data[gi*LANE_WIDTH +: LANE_WIDTH] = w_lane_out;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_state <= SEED;
                end else if (w_accept && en) begin
                    r_state <= w_lane_end;
                end else if (seed_load) begin
                    r_state <= seed_value;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_beat_count <= '0;
        end else if (w_accept) begin
            r_out_valid  <= 1'b1;
            r_out_data   <= en ? w_scr_data : in_data;
            r_beat_count <= r_beat_count + 16'd1;
        end else if (out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

endmodule
